multi_sprite_bouncer: RTL and testbench

//  Parametrised successor to the single bouncing-box image generator.
//  - Animates N_SPRITES independent boxes, each with its own position, velocity and colour.
//  - Updates all sprites once per frame, one sprite per clock, through a small FSM.
//  - Composites sprites by fixed priority into one registered RGB pixel stream.
//  - Sits between the video timer and the pads; sync/visible are delayed to match pixel latency.

---
 rtl/multi_sprite_bouncer.sv | 146 ++++++++++++++
 tb/tb_multi_sprite_bouncer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_sprite_bouncer.sv
// Multi-sprite bouncing-box generator: N boxes advance once per frame, one sprite per clock,
// and are composited by fixed priority into a registered RGB stream aligned with delayed syncs.
module multi_sprite_bouncer #(
   parameter int N_SPRITES = 4,
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int BOX_W     = 100,
   parameter int BOX_H     = 100,
   parameter int COLOR_W   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_frame_tick,
   input  logic [$clog2(SCREEN_W)-1:0] i_pos_x,
   input  logic [$clog2(SCREEN_H)-1:0] i_pos_y,
   input  logic                        i_visible_in,
   input  logic                        i_hsync_in,
   input  logic                        i_vsync_in,
   output logic [COLOR_W-1:0]          o_r,
   output logic [COLOR_W-1:0]          o_g,
   output logic [COLOR_W-1:0]          o_b,
   output logic                        o_hsync,
   output logic                        o_vsync,
   output logic                        o_busy
);
   localparam int XW = $clog2(SCREEN_W) + 1;
   localparam int YW = $clog2(SCREEN_H) + 1;
   localparam int IW = $clog2(N_SPRITES);
   localparam logic signed [XW-1:0] X_MAX = XW'(SCREEN_W - BOX_W);
   localparam logic signed [YW-1:0] Y_MAX = YW'(SCREEN_H - BOX_H);

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_UPDATE = 1'b1;

   logic                 r_state;
   logic [IW-1:0]        r_idx;
   logic signed [XW-1:0] r_x  [N_SPRITES];
   logic signed [XW-1:0] r_xv [N_SPRITES];
   logic signed [YW-1:0] r_y  [N_SPRITES];
   logic signed [YW-1:0] r_yv [N_SPRITES];
   logic [2:0]           r_color [N_SPRITES];

   logic signed [XW-1:0] w_tx;
   logic signed [XW-1:0] w_nextX;
   logic signed [YW-1:0] w_ty;
   logic signed [YW-1:0] w_nextY;
   logic                 w_hitV;
   logic                 w_hitH;
   logic [2:0]           w_nextColor;

   // Next state of the sprite selected by r_idx; a wall touch flips velocity and cycles colour once.
   always_comb begin
      w_tx        = r_x[r_idx] + r_xv[r_idx];
      w_ty        = r_y[r_idx] + r_yv[r_idx];
      w_hitV      = (w_tx < 0) || (w_tx >= X_MAX);
      w_hitH      = (w_ty < 0) || (w_ty >= Y_MAX);
      w_nextX     = (w_tx < 0) ? '0 : ((w_tx > X_MAX) ? X_MAX : w_tx);
      w_nextY     = (w_ty < 0) ? '0 : ((w_ty > Y_MAX) ? Y_MAX : w_ty);
      w_nextColor = (r_color[r_idx] == 3'd7) ? 3'd1 : r_color[r_idx] + 3'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         for (int i = 0; i < N_SPRITES; i++) begin
            r_x[i]     <= XW'((i * (BOX_W + 20)) % (SCREEN_W - BOX_W));
            r_y[i]     <= YW'((i * 40) % (SCREEN_H - BOX_H));
            r_xv[i]    <= XW'(2);
            r_yv[i]    <= (i % 2 == 0) ? YW'(1) : YW'(-1);
            r_color[i] <= 3'((i % 7) + 1);
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_frame_tick) begin
                  r_state <= ST_UPDATE;
                  r_idx   <= '0;
               end
            end
            default: begin
               r_x[r_idx] <= w_nextX;
               r_y[r_idx] <= w_nextY;
               if (w_hitV) r_xv[r_idx] <= -r_xv[r_idx];
               if (w_hitH) r_yv[r_idx] <= -r_yv[r_idx];
               if (w_hitV || w_hitH) r_color[r_idx] <= w_nextColor;
               if (r_idx == IW'(N_SPRITES - 1)) begin
                  r_state <= ST_IDLE;
                  r_idx   <= '0;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
         endcase
      end
   end

   assign o_busy = (r_state == ST_UPDATE);

   logic [XW-1:0] w_px;
   logic [YW-1:0] w_py;
   logic          w_anyHit;
   logic [2:0]    w_winColor;

   assign w_px = XW'(i_pos_x);
   assign w_py = YW'(i_pos_y);

   // Scanning from the highest index down lets the lowest-index sprite overwrite, giving it priority.
   always_comb begin
      w_anyHit   = 1'b0;
      w_winColor = 3'd0;
      for (int i = N_SPRITES - 1; i >= 0; i--) begin
         if (($unsigned(r_x[i]) <= w_px) && (w_px < $unsigned(r_x[i]) + XW'(BOX_W)) &&
             ($unsigned(r_y[i]) <= w_py) && (w_py < $unsigned(r_y[i]) + YW'(BOX_H))) begin
            w_anyHit   = 1'b1;
            w_winColor = r_color[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_r     <= '0;
         o_g     <= '0;
         o_b     <= '0;
         o_hsync <= 1'b1;
         o_vsync <= 1'b1;
      end else begin
         o_hsync <= i_hsync_in;
         o_vsync <= i_vsync_in;
         if (!i_visible_in) begin
            o_r <= '0;
            o_g <= '0;
            o_b <= '0;
         end else if (w_anyHit) begin
            o_r <= {COLOR_W{w_winColor[0]}};
            o_g <= {COLOR_W{w_winColor[1]}};
            o_b <= {COLOR_W{w_winColor[2]}};
         end else begin
            o_r <= COLOR_W'(1);
            o_g <= COLOR_W'(1);
            o_b <= COLOR_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_multi_sprite_bouncer.sv
// Bench for multi_sprite_bouncer: a frame-level sprite model predicts busy, syncs and pixels
// every cycle, and directed probes pin the model against hand-computed positions and colours.
module tb_multi_sprite_bouncer;
   localparam int N  = 4;
   localparam int SW = 640;
   localparam int SH = 480;
   localparam int BW = 100;
   localparam int BH = 100;
   localparam int CW = 4;
   localparam int FULL = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frameTick = 1'b0;
   logic [9:0]    posX = 10'd10;
   logic [8:0]    posY = 9'd10;
   logic          visibleIn = 1'b1;
   logic          hsyncIn = 1'b0;
   logic          vsyncIn = 1'b0;
   logic [CW-1:0] r, g, b;
   logic          hsync, vsync, busy;

   always #5 clk = ~clk;

   multi_sprite_bouncer #(
      .N_SPRITES(N), .SCREEN_W(SW), .SCREEN_H(SH), .BOX_W(BW), .BOX_H(BH), .COLOR_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .i_frame_tick(frameTick),
      .i_pos_x(posX), .i_pos_y(posY), .i_visible_in(visibleIn),
      .i_hsync_in(hsyncIn), .i_vsync_in(vsyncIn),
      .o_r(r), .o_g(g), .o_b(b), .o_hsync(hsync), .o_vsync(vsync), .o_busy(busy)
   );

   int checks = 0;
   int fails  = 0;

   // Model state: whole-frame sprite positions, applied at once when a tick is accepted.
   int mx [N];
   int my [N];
   int mxv[N];
   int myv[N];
   int mc [N];
   int busyLeft = 0;
   bit modelReady = 1'b0;
   bit pixValid = 1'b0;
   int eR = 0, eG = 0, eB = 0, eHs = 1, eVs = 1;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < N; i++) begin
         mx[i]  = (i * (BW + 20)) % (SW - BW);
         my[i]  = (i * 40) % (SH - BH);
         mxv[i] = 2;
         myv[i] = (i % 2 == 0) ? 1 : -1;
         mc[i]  = (i % 7) + 1;
      end
   endtask

   task automatic stepSprite(input int i);
      int tx, ty;
      bit hv, hh;
      tx = mx[i] + mxv[i];
      ty = my[i] + myv[i];
      hv = (tx < 0) || (tx >= SW - BW);
      hh = (ty < 0) || (ty >= SH - BH);
      mx[i] = (tx < 0) ? 0 : ((tx > SW - BW) ? SW - BW : tx);
      my[i] = (ty < 0) ? 0 : ((ty > SH - BH) ? SH - BH : ty);
      if (hv) mxv[i] = -mxv[i];
      if (hh) myv[i] = -myv[i];
      if (hv || hh) mc[i] = (mc[i] == 7) ? 1 : mc[i] + 1;
   endtask

   task automatic modelPixel(input int px, input int py, input bit vis);
      int win;
      win = -1;
      for (int i = 0; i < N; i++)
         if (win < 0 && px >= mx[i] && px < mx[i] + BW && py >= my[i] && py < my[i] + BH)
            win = i;
      if (!vis) begin
         eR = 0; eG = 0; eB = 0;
      end else if (win < 0) begin
         eR = 1; eG = 1; eB = 1;
      end else begin
         eR = (mc[win] & 1) ? FULL : 0;
         eG = (mc[win] & 2) ? FULL : 0;
         eB = (mc[win] & 4) ? FULL : 0;
      end
   endtask

   // Model advances on each rising edge using the inputs the DUT samples there.
   initial begin
      resetModel();
      forever begin
         @(posedge clk);
         if (rst) begin
            resetModel();
            eR = 0; eG = 0; eB = 0; eHs = 1; eVs = 1;
            busyLeft = 0;
            pixValid = 1'b1;
         end else begin
            eHs = hsyncIn;
            eVs = vsyncIn;
            pixValid = (busyLeft == 0);
            modelPixel(int'(posX), int'(posY), visibleIn);
            if (busyLeft > 0) begin
               busyLeft--;
            end else if (frameTick) begin
               busyLeft = N;
               for (int i = 0; i < N; i++) stepSprite(i);
            end
         end
         modelReady = 1'b1;
      end
   end

   // Pixels produced while sprites are only partly updated are not predicted by the frame-level model.
   initial begin
      forever begin
         @(negedge clk);
         if (modelReady) begin
            checkOutput("busy", int'(busy), (busyLeft > 0) ? 1 : 0);
            checkOutput("hsync", int'(hsync), eHs);
            checkOutput("vsync", int'(vsync), eVs);
            if (pixValid) begin
               checkOutput("pix_r", int'(r), eR);
               checkOutput("pix_g", int'(g), eG);
               checkOutput("pix_b", int'(b), eB);
            end
         end
      end
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) begin
         posX      = 10'((int'(posX) + 37) % SW);
         posY      = 9'((int'(posY) + 23) % SH);
         hsyncIn   = ~hsyncIn;
         visibleIn = (k % 5 != 0);
         if (k % 3 == 0) vsyncIn = ~vsyncIn;
         nextCycle();
      end
      visibleIn = 1'b1;
   endtask

   task automatic applyStimulus(input int n);
      for (int t = 0; t < n; t++) begin
         frameTick = 1'b1;
         nextCycle();
         frameTick = 1'b0;
         idleCycles(N + 2);
      end
   endtask

   task automatic probePixel(input string name, input int px, input int py,
                             input int er, input int eg, input int eb);
      posX = 10'(px);
      posY = 9'(py);
      visibleIn = 1'b1;
      nextCycle();
      checkOutput({name, "_r"}, int'(r), er);
      checkOutput({name, "_g"}, int'(g), eg);
      checkOutput({name, "_b"}, int'(b), eb);
   endtask

   int busyCycles;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_r", int'(r), 0);
      checkOutput("rst_g", int'(g), 0);
      checkOutput("rst_b", int'(b), 0);
      checkOutput("rst_hsync", int'(hsync), 1);
      checkOutput("rst_vsync", int'(vsync), 1);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("model_rst_x1", mx[1], 120);
      checkOutput("model_rst_x3", mx[3], 360);
      checkOutput("model_rst_y3", my[3], 120);
      checkOutput("model_rst_c2", mc[2], 3);

      rst = 1'b0;
      hsyncIn = 1'b1;
      vsyncIn = 1'b1;
      probePixel("reset_pix", 10, 10, FULL, 0, 0);
      visibleIn = 1'b0;
      nextCycle();
      checkOutput("blank_r", int'(r), 0);
      checkOutput("blank_g", int'(g), 0);
      checkOutput("blank_b", int'(b), 0);
      visibleIn = 1'b1;

      frameTick = 1'b1;
      nextCycle();
      frameTick = 1'b0;
      busyCycles = 0;
      for (int k = 0; k < 10; k++) begin
         if (busy) busyCycles++;
         nextCycle();
      end
      checkOutput("busy_len", busyCycles, N);
      checkOutput("model_t2_x0", mx[0], 2);
      checkOutput("model_t2_y0", my[0], 1);
      checkOutput("model_t2_x1", mx[1], 122);
      checkOutput("model_t2_y1", my[1], 39);
      probePixel("t2_in0", 2, 1, FULL, 0, 0);
      probePixel("t2_bg", 1, 1, 1, 1, 1);

      frameTick = 1'b1;
      nextCycle();
      busyCycles = 0;
      for (int k = 0; k < 12; k++) begin
         if (busy) busyCycles++;
         frameTick = (k == 1);
         nextCycle();
      end
      frameTick = 1'b0;
      checkOutput("busy_len_retick", busyCycles, N);
      checkOutput("model_t5_x0", mx[0], 4);

      applyStimulus(228);
      checkOutput("model_t230_x1", mx[1], 500);
      checkOutput("model_t230_y1", my[1], 189);
      checkOutput("model_t230_c1", mc[1], 4);
      probePixel("overlap", 510, 240, FULL, 0, 0);
      probePixel("sprite1_only", 560, 240, 0, 0, FULL);

      applyStimulus(40);
      checkOutput("model_t270_x0", mx[0], 540);
      checkOutput("model_t270_xv0", mxv[0], -2);
      checkOutput("model_t270_c0", mc[0], 2);
      applyStimulus(1);
      checkOutput("model_t271_x0", mx[0], 538);
      probePixel("t271_in0", 538, 300, 0, FULL, 0);
      probePixel("t271_bg", 537, 300, 1, 1, 1);

      frameTick = 1'b1;
      nextCycle();
      frameTick = 1'b0;
      nextCycle();
      nextCycle();
      rst = 1'b1;
      nextCycle();
      checkOutput("abort_busy", int'(busy), 0);
      rst = 1'b0;
      checkOutput("model_abort_x0", mx[0], 0);
      probePixel("abort_s0", 10, 10, FULL, 0, 0);
      probePixel("abort_s1", 125, 45, 0, FULL, 0);
      idleCycles(10);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
